// File: rtl/ohsm_seq_checker_if.sv
// Phase-bus interface between the one-hot sequencer (master) and its receive-side checker (slave).
interface ohsm_seq_checker_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    logic             en;
    logic [W-1:0]     SGlobal_in;
    logic             clr_err;
    logic [IW-1:0]    idx;
    logic [IW:0]      ValorEstado;
    logic             valid_onehot;
    logic             tracking;
    logic             seq_err;
    logic [1:0]       err_code;
    logic             cycle_done;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output en, SGlobal_in, clr_err,
        input  idx, ValorEstado, valid_onehot, tracking, seq_err, err_code, cycle_done, cycle_cnt
    );

    modport slave (
        input  en, SGlobal_in, clr_err,
        output idx, ValorEstado, valid_onehot, tracking, seq_err, err_code, cycle_done, cycle_cnt
    );
endinterface

// File: rtl/ohsm_seq_checker.sv
// Receive-side checker for the one-hot phase sequencer: samples the phase bus, decodes it,
// checks S1->S2->...->S_W->S1 ordering and counts completed cycles.
module ohsm_seq_checker #(
    parameter int W     = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    ohsm_seq_checker_if.slave   bus
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     samp_q;
    logic [IW-1:0]    prev_q, prev_d;
    logic [1:0]       code_q, code_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [IW-1:0]    sidx;
    logic             svalid;
    logic             wrap;
    logic             step_ok;

    // Stage 1: phase sample register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp_q <= '0;
        end else if (bus.en) begin
            samp_q <= bus.SGlobal_in;
        end
    end

    // Decode: MSB is S1 (index 0); illegal words report index 0
    always_comb begin
        int unsigned ones;
        logic [IW-1:0] pos;
        ones = 0;
        pos  = '0;
        for (int unsigned i = 0; i < W; i++) begin
            if (samp_q[i]) begin
                ones = ones + 1;
                pos  = IW'(W - 1 - i);
            end
        end
        svalid = (ones == 1);
        sidx   = svalid ? pos : '0;
    end

    // Stage 2: checker state and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SYNC;
            prev_q  <= '0;
            code_q  <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            code_q  <= code_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    // S1 may repeat while the sequencer waits to start; otherwise only +1 steps and the wrap are legal
    always_comb begin
        wrap    = (prev_q == IW'(W - 1)) && (sidx == '0);
        step_ok = wrap
               || ((prev_q == '0) && (sidx == '0))
               || ({1'b0, sidx} == ({1'b0, prev_q} + (IW+1)'(1)));
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        code_d  = code_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        if (bus.clr_err) begin
            state_d = SYNC;
            code_d  = '0;
        end else if (bus.en) begin
            case (state_q)
                SYNC: begin
                    if (svalid && (sidx == '0)) begin
                        state_d = TRACK;
                        prev_d  = '0;
                    end
                end
                TRACK: begin
                    if (!svalid) begin
                        state_d = ERROR;
                        code_d  = 2'b01;
                    end else if (step_ok) begin
                        prev_d = sidx;
                        if (wrap) begin
                            done_d = 1'b1;
                            if (cnt_q != '1) begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end else begin
                        state_d = ERROR;
                        code_d  = 2'b10;
                    end
                end
                ERROR:   state_d = ERROR;
                default: state_d = SYNC;
            endcase
        end
    end

    always_comb begin
        bus.idx          = sidx;
        bus.ValorEstado  = svalid ? ({1'b0, sidx} + (IW+1)'(1)) : '0;
        bus.valid_onehot = svalid;
        bus.tracking     = (state_q == TRACK);
        bus.seq_err      = (state_q == ERROR);
        bus.err_code     = code_q;
        bus.cycle_done   = done_q & bus.en;
        bus.cycle_cnt    = cnt_q;
    end
endmodule

// File: tb/tb_ohsm_seq_checker.sv
// Randomised and directed bench for ohsm_seq_checker against a behavioural phase-ordering model.
module tb_ohsm_seq_checker;
    localparam int W  = 4;
    localparam int IW = 2;
    localparam int VW = IW + (IW + 1) + 6 + 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ohsm_seq_checker_if #(.W(W), .CNT_W(8)) b8 ();
    ohsm_seq_checker_if #(.W(W), .CNT_W(2)) b2 ();

    assign b2.en         = b8.en;
    assign b2.clr_err    = b8.clr_err;
    assign b2.SGlobal_in = b8.SGlobal_in;

    ohsm_seq_checker #(.W(W), .CNT_W(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));
    ohsm_seq_checker #(.W(W), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(b2));

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: last sampled word, lock flag, last legal phase, first error, total cycles
    logic [W-1:0] m_samp;
    bit           m_locked;
    bit           m_err;
    int           m_prev;
    logic [1:0]   m_code;
    bit           m_done;
    int           m_total;

    function automatic int pos_of(input logic [W-1:0] w);
        if ($countones(w) != 1) return -1;
        for (int i = 0; i < W; i++) if (w[W-1-i]) return i;
        return -1;
    endfunction

    function automatic logic [W-1:0] phase_word(input int p);
        logic [W-1:0] w;
        w = '0;
        w[W-1-p] = 1'b1;
        return w;
    endfunction

    task automatic model_reset();
        m_samp = '0; m_locked = 0; m_err = 0; m_prev = 0; m_code = '0; m_done = 0; m_total = 0;
    endtask

    function automatic logic [VW-1:0] exp_vec();
        int p;
        logic [IW-1:0] ei;
        logic [IW:0]   ev;
        logic [7:0]    c8;
        p  = pos_of(m_samp);
        ei = (p < 0) ? '0 : IW'(p);
        ev = (p < 0) ? '0 : (IW+1)'(p + 1);
        c8 = (m_total > 255) ? 8'hFF : 8'(m_total);
        return {ei, ev, p >= 0, m_locked && !m_err, m_err, m_code, m_done && b8.en, c8};
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {b8.idx, b8.ValorEstado, b8.valid_onehot, b8.tracking, b8.seq_err,
                b8.err_code, b8.cycle_done, b8.cycle_cnt};
    endfunction

    function automatic logic [1:0] exp_cnt2();
        return (m_total > 3) ? 2'd3 : 2'(m_total);
    endfunction

    task automatic drive(input bit en, input bit clr, input logic [W-1:0] sg);
        b8.en = en; b8.clr_err = clr; b8.SGlobal_in = sg;
    endtask

    // Advance one clock edge and apply the same edge to the model
    task automatic tick();
        int p;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            p = pos_of(m_samp);
            if (b8.clr_err) begin
                m_locked = 0; m_err = 0; m_code = '0; m_done = 0;
            end else if (b8.en) begin
                m_done = 0;
                if (m_err) begin
                end else if (!m_locked) begin
                    if (p == 0) begin m_locked = 1; m_prev = 0; end
                end else if (p < 0) begin
                    m_err = 1; m_locked = 0; m_code = 2'b01;
                end else if (p == (m_prev + 1) % W || (m_prev == 0 && p == 0)) begin
                    if (m_prev == W - 1 && p == 0) begin m_done = 1; m_total++; end
                    m_prev = p;
                end else begin
                    m_err = 1; m_locked = 0; m_code = 2'b10;
                end
            end else begin
                m_done = 0;
            end
            if (b8.en) m_samp = b8.SGlobal_in;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [VW-1:0] got;
        model_reset();
        drive(1, 0, 4'b1000);
        #2;
        got = dut_vec();
        n_checks++;
        if (got !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got=%h exp=%h", got, {VW{1'b0}});
        end
        tick();
        reset = 1'b1;
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_hold: got=%h exp=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_basic_cycle();
        logic [W-1:0] seq [8] = '{4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b1000, 4'b1000};
        int exp_idx [6] = '{0, 0, 1, 2, 3, 0};
        int pulses = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, seq[i]);
            tick();
            if (b8.cycle_done) pulses++;
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL basic_vec[%0d]: got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (i < 6) begin
                n_checks++;
                if (b8.idx !== IW'(exp_idx[i]) || b8.ValorEstado !== (IW+1)'(exp_idx[i] + 1)) begin
                    n_fail++;
                    $display("FAIL basic_decode[%0d]: got idx=%0d val=%0d exp idx=%0d val=%0d",
                             i, b8.idx, b8.ValorEstado, exp_idx[i], exp_idx[i] + 1);
                end
            end
        end
        n_checks++;
        if (pulses != 1 || b8.cycle_cnt !== 8'd1 || b8.seq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_count: got pulses=%0d cnt=%0d err=%0b exp pulses=1 cnt=1 err=0",
                     pulses, b8.cycle_cnt, b8.seq_err);
        end
    endtask

    task automatic test_not_onehot();
        logic [W-1:0] seq [5] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b1000};
        drive(1, 0, 4'b0110);
        tick();
        n_checks++;
        if (b8.valid_onehot !== 1'b0 || b8.ValorEstado !== '0 || b8.idx !== '0) begin
            n_fail++;
            $display("FAIL noh_decode: got valid=%0b val=%0d idx=%0d exp 0 0 0",
                     b8.valid_onehot, b8.ValorEstado, b8.idx);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, seq[i]);
            tick();
            n_checks++;
            if (b8.seq_err !== 1'b1 || b8.err_code !== 2'b01 || b8.tracking !== 1'b0) begin
                n_fail++;
                $display("FAIL noh_sticky[%0d]: got err=%0b code=%0d trk=%0b exp 1 1 0",
                         i, b8.seq_err, b8.err_code, b8.tracking);
            end
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL noh_vec[%0d]: got=%h exp=%h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_skip_and_clear();
        logic [7:0] saved;
        drive(1, 1, 4'b1000); tick();
        drive(1, 0, 4'b1000); tick();
        drive(1, 0, 4'b0010); tick();
        tick();
        n_checks++;
        if (b8.seq_err !== 1'b1 || b8.err_code !== 2'b10) begin
            n_fail++; $display("FAIL skip_code: got err=%0b code=%0d exp err=1 code=2", b8.seq_err, b8.err_code);
        end
        saved = b8.cycle_cnt;
        drive(1, 1, 4'b0110); tick();
        n_checks++;
        if (b8.seq_err !== 1'b0 || b8.err_code !== 2'b00 || b8.tracking !== 1'b0 || b8.cycle_cnt !== saved) begin
            n_fail++;
            $display("FAIL clr_err: got err=%0b code=%0d trk=%0b cnt=%0d exp 0 0 0 %0d",
                     b8.seq_err, b8.err_code, b8.tracking, b8.cycle_cnt, saved);
        end
        drive(1, 0, 4'b1000); tick();
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL clr_sync_ignore: got=%h exp=%h", dut_vec(), exp_vec());
        end
        tick();
        n_checks++;
        if (b8.tracking !== 1'b1 || b8.seq_err !== 1'b0) begin
            n_fail++; $display("FAIL relock: got trk=%0b err=%0b exp trk=1 err=0", b8.tracking, b8.seq_err);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_c [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [1:0] seen [5];
        int pulses = 0;
        reset = 1'b0; tick(); reset = 1'b1;
        drive(1, 0, 4'b1000); tick();
        for (int c = 0; c < 6; c++) begin
            for (int p = 1; p <= W; p++) begin
                drive(1, 0, (c < 5) ? phase_word(p % W) : 4'b1000);
                tick();
                if (b2.cycle_done) begin
                    if (pulses < 5) seen[pulses] = b2.cycle_cnt;
                    pulses++;
                end
                n_checks++;
                if (b2.cycle_cnt !== exp_cnt2() || b2.cycle_done !== (m_done && b8.en)) begin
                    n_fail++;
                    $display("FAIL sat_track: got cnt=%0d done=%0b exp cnt=%0d done=%0b",
                             b2.cycle_cnt, b2.cycle_done, exp_cnt2(), m_done);
                end
            end
        end
        n_checks++;
        if (pulses != 5) begin
            n_fail++; $display("FAIL sat_pulses: got %0d exp 5", pulses);
        end
        for (int i = 0; i < 5 && i < pulses; i++) begin
            n_checks++;
            if (seen[i] !== exp_c[i]) begin
                n_fail++; $display("FAIL sat_cnt[%0d]: got %0d exp %0d", i, seen[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_pre_sync();
        reset = 1'b0; tick(); reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 4'b0100);
            tick();
            n_checks++;
            if (b8.tracking !== 1'b0 || b8.seq_err !== 1'b0) begin
                n_fail++; $display("FAIL presync[%0d]: got trk=%0b err=%0b exp 0 0", i, b8.tracking, b8.seq_err);
            end
        end
        drive(1, 0, 4'b1000); tick(); tick();
        n_checks++;
        if (b8.tracking !== 1'b1) begin
            n_fail++; $display("FAIL presync_lock: got trk=%0b exp 1", b8.tracking);
        end
    endtask

    task automatic test_async_reset();
        logic [VW-1:0] got;
        drive(1, 0, 4'b0100); tick();
        drive(1, 0, 4'b0010); tick();
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        got = dut_vec();
        n_checks++;
        if (got !== '0 || b2.cycle_cnt !== '0 || b2.tracking !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got=%h exp=%h", got, {VW{1'b0}});
        end
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 4'b0001);
            tick();
            n_checks++;
            if (b8.seq_err !== 1'b0 || b8.cycle_cnt !== 8'd0 || b8.tracking !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got err=%0b cnt=%0d trk=%0b exp 0 0 0",
                         i, b8.seq_err, b8.cycle_cnt, b8.tracking);
            end
        end
    endtask

    task automatic test_en_pause();
        logic [W-1:0] seq [7] = '{4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000, 4'b1000};
        for (int i = 0; i < 7; i++) begin
            drive(1, 0, seq[i]);
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL pause_vec[%0d]: got=%h exp=%h", i, dut_vec(), exp_vec());
            end
            if (i == 3 || i == 5) begin
                for (int k = 0; k < 3; k++) begin
                    drive(0, 0, 4'($urandom_range(0, 15)));
                    tick();
                    n_checks++;
                    if (dut_vec() !== exp_vec() || b8.cycle_done !== 1'b0) begin
                        n_fail++; $display("FAIL pause_hold[%0d.%0d]: got=%h exp=%h", i, k, dut_vec(), exp_vec());
                    end
                end
            end
        end
        n_checks++;
        if (b8.tracking !== 1'b1 || b8.seq_err !== 1'b0) begin
            n_fail++; $display("FAIL pause_track: got trk=%0b err=%0b exp 1 0", b8.tracking, b8.seq_err);
        end
    endtask

    task automatic test_random();
        int ph = 0;
        int r;
        logic [W-1:0] w;
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6) ph = (ph + 1) % W;
            w = (r < 8) ? phase_word(ph) : 4'($urandom_range(0, 15));
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 14) == 0, w);
            tick();
            n_checks++;
            if (dut_vec() !== exp_vec() || b2.cycle_cnt !== exp_cnt2()) begin
                n_fail++;
                $display("FAIL random[%0d]: got=%h cnt2=%0d exp=%h cnt2=%0d",
                         i, dut_vec(), b2.cycle_cnt, exp_vec(), exp_cnt2());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_cycle();
        test_not_onehot();
        test_skip_and_clear();
        test_saturation();
        test_pre_sync();
        test_async_reset();
        test_en_pause();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
